// File: rtl/clock_display_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package clock_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [IDX_W-1:0] digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    // Frame-start copy of everything the display depends on
    typedef struct packed {
        logic [3:0] hour2;
        logic [3:0] hour1;
        logic [3:0] min2;
        logic [3:0] min1;
        logic [3:0] sec2;
        logic [3:0] sec1;
        logic       ampm;
        logic       alarm_flag;
        logic       show_sec;
    } snap_t;

    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        logic [3:0] an;
        an = AN_OFF;
        case (idx)
            2'd0: an = AN_DIG0;
            2'd1: an = AN_DIG1;
            2'd2: an = AN_DIG2;
            2'd3: an = AN_DIG3;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/clock_display_driver_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes 10-15 render as a dash.
module bcd_to_seg
    import clock_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_driver.sv
// Time-multiplexed scan driver for a 4-digit 7-segment display showing
// HH:MM or MM:SS with blinking colon, PM dot and alarm blink.
module clock_display_driver
    import clock_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour2,
    input  logic [3:0] hour1,
    input  logic [3:0] min2,
    input  logic [3:0] min1,
    input  logic [3:0] sec2,
    input  logic [3:0] sec1,
    input  logic       ampm,
    input  logic       alarm_flag,
    input  logic       show_sec,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    logic [RW-1:0] r_refresh_cnt;
    logic [BW-1:0] r_blink_cnt;
    digit_idx_t    r_idx;
    logic          r_blink_on;
    snap_t         r_snap;

    logic          w_refresh_tc;
    logic          w_blink_tc;
    snap_t         w_snap_in;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_dec;
    logic [6:0]    w_seg;
    logic          w_dp;

    assign w_refresh_tc = (r_refresh_cnt == RW'(REFRESH_DIV - 1));
    assign w_blink_tc   = (r_blink_cnt == BW'(BLINK_DIV - 1));

    assign w_snap_in = '{
        hour2:      hour2,
        hour1:      hour1,
        min2:       min2,
        min1:       min1,
        sec2:       sec2,
        sec1:       sec1,
        ampm:       ampm,
        alarm_flag: alarm_flag,
        show_sec:   show_sec
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_idx         <= '0;
        end else if (w_refresh_tc) begin
            r_refresh_cnt <= '0;
            r_idx         <= r_idx + digit_idx_t'(1);
        end else begin
            r_refresh_cnt <= r_refresh_cnt + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_blink_tc) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Latch at the frame boundary so a frame never mixes old and new time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_refresh_tc && (r_idx == LAST_IDX)) begin
            r_snap <= w_snap_in;
        end
    end

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        if (r_snap.show_sec) begin
            case (r_idx)
                2'd3:    w_digit = r_snap.min2;
                2'd2:    w_digit = r_snap.min1;
                2'd1:    w_digit = r_snap.sec2;
                default: w_digit = r_snap.sec1;
            endcase
        end else begin
            case (r_idx)
                2'd3: begin
                    w_digit = r_snap.hour2;
                    w_blank = (r_snap.hour2 == 4'd0);
                end
                2'd2:    w_digit = r_snap.hour1;
                2'd1:    w_digit = r_snap.min2;
                default: w_digit = r_snap.min1;
            endcase
        end
    end

    bcd_to_seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec)
    );

    always_comb begin
        w_seg = w_blank ? SEG_BLANK : w_dec;
        w_dp  = 1'b1;
        if ((r_idx == 2'd2) && r_blink_on) begin
            w_dp = 1'b0;
        end
        if ((r_idx == 2'd0) && r_snap.ampm && !r_snap.show_sec) begin
            w_dp = 1'b0;
        end
        // Alarm blanks segments only; anodes keep scanning
        if (r_snap.alarm_flag && !r_blink_on) begin
            w_seg = SEG_BLANK;
            w_dp  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= anode_for(r_idx);
            seg <= w_seg;
            dp  <= w_dp;
        end
    end

endmodule
